wb_pipeline_master: RTL and testbench
=====================================

# wb_pipeline_master

Synthesizable WISHBONE pipelined master (no burst, CTI classic) that carries one NIC transaction of up to `MAX_BURST_LENGHT` data beats onto the bus. It requests the bus from the arbiter, issues the beats with STB while honouring STALL, counts ACKs, captures read data, and reports completion and status to the NIC core. It is the initiator counterpart of the simulation-only pipelined slave, and the two are bench-connected back to back.

## Interface
- `MAX_BEATS`, `MAX_BURST_LENGHT`: maximum beats per transaction; sizes the data buffers.
- `LEN_W`, `$clog2(MAX_BEATS+1)`: width of `len_i`.
- `TIMEOUT_CYCLES`, 64: watchdog limit, used only with `WB_MASTER_TIMEOUT_EN`.
- One clock; reset is synchronous and active-low.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start_i` in 1: transaction request, sampled only in IDLE.
- `we_i` in 1: 1 = write, 0 = read.
- `adr_i` in `BUS_ADDRESS_WIDTH`: packet address, held constant on every beat.
- `len_i` in `LEN_W`: beat count. Values above `MAX_BEATS` are clamped to `MAX_BEATS`.
- `wr_data_i` in `MAX_BEATS*BUS_DATA_WIDTH`: write beats, beat 0 in the LSBs; captured at start.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle completion pulse.
- `err_o`, `rty_o`, `tmo_o` out 1 each: status flags, valid together with `done_o` and held until the next start.
- `rd_data_o` out `MAX_BEATS*BUS_DATA_WIDTH`: read beats, beat 0 in the LSBs.
- `req_wb_o` out 1: arbiter request. `gnt_wb_i` in 1: arbiter grant.
- `CYC_O`, `STB_O`, `WE_O` out 1; `ADR_O` out `BUS_ADDRESS_WIDTH`; `DAT_O` out `BUS_DATA_WIDTH`; `SEL_O` out `BUS_DATA_WIDTH/GRANULARITY`, all ones; `CTI_O` out 3, constant 3'b000.
- `DAT_I` in `BUS_DATA_WIDTH`; `ACK_I`, `ERR_I`, `RTY_I`, `STALL_I` in 1.

## Operation
- FSM states: IDLE, REQ, XFER, DONE.
- IDLE:
  - `start_i` with clamped len ≥ 1: latch `we_i`, `adr_i`, len and `wr_data_i`; clear the status flags and both counters; go to REQ.
  - `start_i` with len = 0: go to DONE directly, with no bus activity.
- REQ: `req_wb_o` = 1. Go to XFER on the cycle after `gnt_wb_i` is seen high.
- XFER:
  - `CYC_O` = 1. `STB_O` = (`issued` < len).
  - A beat is accepted on any edge with `STB_O && !STALL_I`; `issued` increments.
  - `DAT_O` = write beat[`issued`]; `ADR_O` = latched address.
  - `ACK_I` increments `acked`; on a read it also stores `DAT_I` into slot `acked`.
  - `acked` == len → DONE.
- Abort: `ERR_I` or `RTY_I` in XFER sets `err_o` / `rty_o` respectively and goes to DONE. An ACK in the same cycle as ERR/RTY is not counted.
- `gnt_wb_i` deasserting during XFER is ignored; the bus is held until completion or abort.
- `start_i` while busy is ignored. ACK with `acked` == `issued` (spurious) is ignored.
- DONE: `done_o` = 1, `CYC_O`/`STB_O` = 0, `req_wb_o` = 0. Return to IDLE on the next cycle.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counters 0, `rd_data_o` 0. `SEL_O` is all ones and `CTI_O` is 0 at all times.
- Reset asserted in any state returns the FSM to IDLE on that edge and drops CYC/STB immediately, with no `done_o` pulse.
- Latency with grant after 1 REQ cycle, no stall and ACK one cycle after each STB:
  - start at cycle 0; REQ at 1; CYC/STB at 2; last STB at 1+len; last ACK at 2+len; `done_o` at 3+len.
- Counters are `LEN_W` bits wide; `issued` never exceeds len, so there is no wrap-around.
- The beat-index buffers use indices 0..`MAX_BEATS`-1 only.

## Configuration
- `WB_MASTER_TIMEOUT_EN` defined: a watchdog counter runs in XFER.
  - It clears on every ACK and on entering XFER.
  - When it reaches `TIMEOUT_CYCLES` it sets `tmo_o` and goes to DONE.
- `WB_MASTER_TIMEOUT_EN` undefined: no watchdog; `tmo_o` is tied to 0; XFER waits indefinitely.

## Structure
- The FSM state encoding and the `wb_pipeline_master` status bit positions go in the shared package alongside the `NIC-defines` constants.
- Bus widths and `MAX_BURST_LENGHT` come from the existing defines.
- Sub-module `wb_master_watchdog`: a counter with clear, enable and expire output, instantiated only under the macro.

## Test plan
- Write, len = 4, grant after 1 cycle, no stall, against the fake slave → 4 STBs, slave stores words 0..3, `done_o` at cycle 7, all flags 0.
- Read, len = 3, slave inserting random stalls → exactly 3 accepted beats, `rd_data_o` equals the slave's reply beats 0..2 in order, `done_o` one cycle after the third ACK.
- ERR_I together with ACK on beat 2 of 4 → `acked` stays 1, `err_o` = 1, CYC drops the next cycle, `done_o` pulses once.
- len = 0 and len = `MAX_BEATS`+5 → respectively no `req_wb_o` with `done_o` at cycle 1, and exactly `MAX_BEATS` beats.
- Reset pulled low mid-XFER after 2 beats → all outputs 0 on the next edge, no `done_o`; a new start afterwards completes normally.
- With `WB_MASTER_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8 and the slave never ACKing → `tmo_o` = 1 and `done_o` 8 cycles after entering XFER.

Source files
------------

// File: rtl/wb_pipeline_master_pkg.sv
// Shared constants for the NIC WISHBONE pipelined master: bus geometry,
// FSM state encoding, status flag bit positions and the length clamp helper.
package wb_pipeline_master_pkg;

  localparam int BUS_DATA_WIDTH    = 32;
  localparam int BUS_ADDRESS_WIDTH = 32;
  localparam int GRANULARITY       = 8;
  localparam int MAX_BURST_LENGHT  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } wbm_state_e;

  localparam int STAT_ERR = 0;
  localparam int STAT_RTY = 1;
  localparam int STAT_TMO = 2;
  localparam int STAT_W   = 3;

  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/wb_master_watchdog.sv
// Idle-bus watchdog: counts enabled cycles since the last clear and flags expiry
// on the LIMIT-th consecutive cycle without a clear.
module wb_master_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CW'(1);
    end
  end

  // A clear in the same cycle (an ACK) always wins over expiry.
  assign o_expire = i_en && !i_clr && (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/wb_pipeline_master.sv
// WISHBONE pipelined master carrying one NIC transaction of up to MAX_BEATS beats.
// Define WB_MASTER_TIMEOUT_EN to enable the XFER watchdog (sets tmo_o on expiry).
module wb_pipeline_master
  import wb_pipeline_master_pkg::*;
#(
  parameter int MAX_BEATS      = MAX_BURST_LENGHT,
  parameter int LEN_W          = $clog2(MAX_BEATS + 1),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start_i,
  input  logic                                    we_i,
  input  logic [BUS_ADDRESS_WIDTH-1:0]            adr_i,
  input  logic [LEN_W-1:0]                        len_i,
  input  logic [MAX_BEATS*BUS_DATA_WIDTH-1:0]     wr_data_i,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic                                    err_o,
  output logic                                    rty_o,
  output logic                                    tmo_o,
  output logic [MAX_BEATS*BUS_DATA_WIDTH-1:0]     rd_data_o,
  output logic                                    req_wb_o,
  input  logic                                    gnt_wb_i,
  output logic                                    CYC_O,
  output logic                                    STB_O,
  output logic                                    WE_O,
  output logic [BUS_ADDRESS_WIDTH-1:0]            ADR_O,
  output logic [BUS_DATA_WIDTH-1:0]               DAT_O,
  output logic [BUS_DATA_WIDTH/GRANULARITY-1:0]   SEL_O,
  output logic [2:0]                              CTI_O,
  input  logic [BUS_DATA_WIDTH-1:0]               DAT_I,
  input  logic                                    ACK_I,
  input  logic                                    ERR_I,
  input  logic                                    RTY_I,
  input  logic                                    STALL_I
);

  localparam int DW = BUS_DATA_WIDTH;
  localparam int AW = BUS_ADDRESS_WIDTH;

  wbm_state_e               r_state;
  logic                     r_busy, r_done, r_req, r_cyc, r_stb, r_we;
  logic [AW-1:0]            r_adr;
  logic [DW-1:0]            r_dat;
  logic [LEN_W-1:0]         r_len, r_issued, r_acked;
  logic [STAT_W-1:0]        r_status;
  logic [MAX_BEATS*DW-1:0]  r_wr_data, r_rd_data;

  logic [LEN_W-1:0]         w_len_clamped, w_issued_nxt, w_acked_nxt;
  logic [DW-1:0]            w_next_dat;
  logic                     w_accept, w_ack_ok, w_abort, w_complete, w_wdt_expire;

  assign w_len_clamped = LEN_W'(clamp_len(int'(len_i), MAX_BEATS));
  assign w_issued_nxt  = r_issued + LEN_W'(1);
  assign w_acked_nxt   = r_acked + LEN_W'(1);
  assign w_accept      = r_stb && !STALL_I;
  // Only ACKs for beats already on the bus count; anything else is spurious.
  assign w_ack_ok      = ACK_I && (r_acked < r_issued);
  assign w_abort       = ERR_I || RTY_I;
  assign w_complete    = w_ack_ok && (w_acked_nxt == r_len);

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_next_dat = '0;
    if (int'(w_issued_nxt) < MAX_BEATS) begin
      w_next_dat = r_wr_data[int'(w_issued_nxt)*DW +: DW];
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  wb_master_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    ((r_state != ST_XFER) || ACK_I),
    .i_en     (r_state == ST_XFER),
    .o_expire (w_wdt_expire)
  );
`else
  assign w_wdt_expire = 1'b0;
`endif

  // NOTE: write payload carries no reset; it is always loaded on start before being read.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && start_i) begin
      r_wr_data <= wr_data_i;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_req     <= 1'b0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_len     <= '0;
      r_issued  <= '0;
      r_acked   <= '0;
      r_status  <= '0;
      r_rd_data <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_busy   <= 1'b1;
            r_status <= '0;
            r_issued <= '0;
            r_acked  <= '0;
            if (w_len_clamped == '0) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_we    <= we_i;
              r_adr   <= adr_i;
              r_len   <= w_len_clamped;
              r_req   <= 1'b1;
              r_state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (gnt_wb_i) begin
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_dat   <= r_wr_data[DW-1:0];
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_abort) begin
            r_status[STAT_ERR] <= ERR_I;
            r_status[STAT_RTY] <= RTY_I;
          end else if (w_wdt_expire) begin
            r_status[STAT_TMO] <= 1'b1;
          end else begin
            if (w_accept) begin
              r_issued <= w_issued_nxt;
              r_stb    <= (w_issued_nxt < r_len);
              r_dat    <= w_next_dat;
            end
            if (w_ack_ok) begin
              r_acked <= w_acked_nxt;
              if (!r_we) begin
                r_rd_data[int'(r_acked)*DW +: DW] <= DAT_I;
              end
            end
          end
          if (w_abort || w_wdt_expire || w_complete) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_req   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_status[STAT_ERR];
  assign rty_o     = r_status[STAT_RTY];
  assign tmo_o     = r_status[STAT_TMO];
  assign rd_data_o = r_rd_data;
  assign req_wb_o  = r_req;
  assign CYC_O     = r_cyc;
  assign STB_O     = r_stb;
  assign WE_O      = r_we;
  assign ADR_O     = r_adr;
  assign DAT_O     = r_dat;
  assign SEL_O     = '1;
  assign CTI_O     = 3'b000;

endmodule

// File: tb/tb_wb_pipeline_master.sv
// Self-checking bench for wb_pipeline_master: a behavioural pipelined slave with
// random stalls/ACK gaps, a grant model, and a beat-level reference of expected data.
module tb_wb_pipeline_master;
  import wb_pipeline_master_pkg::*;

  localparam int MB  = MAX_BURST_LENGHT;
  localparam int LW  = $clog2(MB + 1);
  localparam int DW  = BUS_DATA_WIDTH;
  localparam int AW  = BUS_ADDRESS_WIDTH;
  localparam int SW  = DW / GRANULARITY;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_i = 1'b0, we_i = 1'b0;
  logic [AW-1:0]    adr_i = '0;
  logic [LW-1:0]    len_i = '0;
  logic [MB*DW-1:0] wr_data_i = '0;
  logic busy_o, done_o, err_o, rty_o, tmo_o, req_wb_o;
  logic [MB*DW-1:0] rd_data_o;
  logic gnt_wb_i = 1'b0;
  logic CYC_O, STB_O, WE_O;
  logic [AW-1:0] ADR_O;
  logic [DW-1:0] DAT_O;
  logic [SW-1:0] SEL_O;
  logic [2:0]    CTI_O;
  logic [DW-1:0] DAT_I = '0;
  logic ACK_I = 1'b0, ERR_I = 1'b0, RTY_I = 1'b0, STALL_I = 1'b0;

  always #5 clk = ~clk;

  wb_pipeline_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .we_i(we_i), .adr_i(adr_i), .len_i(len_i),
    .wr_data_i(wr_data_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rty_o(rty_o),
    .tmo_o(tmo_o), .rd_data_o(rd_data_o), .req_wb_o(req_wb_o), .gnt_wb_i(gnt_wb_i),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
    .CTI_O(CTI_O), .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I), .STALL_I(STALL_I)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave / monitor state and knobs
  logic [DW-1:0] reply   [MB];
  logic [DW-1:0] slv_wr  [MB];
  logic [DW-1:0] model_rd[MB];
  logic [MB*DW-1:0] wd_last;
  logic [AW-1:0] exp_adr = '0;
  int pend[$];
  int b;
  int n_acc = 0, n_done = 0, n_ack = 0, req_seen = 0, adr_bad = 0;
  int done_cyc = -1, last_ack_cyc = -1, xfer_cyc = -1, start_cyc = 0;
  int cyc_at_done = 0, busy_at_done = 0;
  int gnt_delay = 0, req_run = 0, stall_pct = 0, gap_pct = 0, err_beat = 99;
  bit abort_rty = 0, ack_en = 1;

  always @(negedge clk) begin
    if (!rst) begin
      pend.delete();
      gnt_wb_i = 0; STALL_I = 0; ACK_I = 0; ERR_I = 0; RTY_I = 0; DAT_I = '0; req_run = 0;
    end else begin
      if (done_o) begin
        n_done++; done_cyc = cyc; cyc_at_done = int'(CYC_O); busy_at_done = int'(busy_o);
      end
      if (req_wb_o) req_seen = 1;
      if (CYC_O && xfer_cyc < 0) xfer_cyc = cyc;
      gnt_wb_i = req_wb_o && (req_run >= gnt_delay);
      req_run  = req_wb_o ? req_run + 1 : 0;
      if (!CYC_O) pend.delete();
      STALL_I = CYC_O && STB_O && ($urandom_range(99) < stall_pct);
      ACK_I = 0; ERR_I = 0; RTY_I = 0; DAT_I = '0;
      if (ack_en && pend.size() > 0 && $urandom_range(99) >= gap_pct) begin
        b = pend.pop_front();
        ACK_I = 1; DAT_I = reply[b]; n_ack++; last_ack_cyc = cyc;
        if (b == err_beat) begin
          if (abort_rty) RTY_I = 1; else ERR_I = 1;
        end
      end
      if (CYC_O && STB_O && !STALL_I) begin
        if (n_acc < MB) slv_wr[n_acc] = DAT_O;
        if (ADR_O !== exp_adr) adr_bad++;
        pend.push_back(n_acc);
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  // Reference: beats counted before an abort, and the slots a read overwrites.
  function automatic int counted_beats(input int len_clamped, input int eb);
    return (eb < len_clamped) ? eb : len_clamped;
  endfunction

  function automatic int cnt_data_bad(input bit we, input int n);
    int bad = 0;
    if (we) begin
      for (int i = 0; i < n && i < MB; i++) if (slv_wr[i] !== wd_last[i*DW +: DW]) bad++;
    end else begin
      for (int i = 0; i < MB; i++) if (rd_data_o[i*DW +: DW] !== model_rd[i]) bad++;
    end
    return bad;
  endfunction

  task automatic launch(input bit we, input int len, input int gd, input int sp, input int gp,
                        input int eb, input bit rty);
    for (int i = 0; i < MB; i++) begin
      reply[i] = $urandom; slv_wr[i] = '0; wd_last[i*DW +: DW] = $urandom;
    end
    n_acc = 0; n_done = 0; n_ack = 0; req_seen = 0; adr_bad = 0;
    done_cyc = -1; last_ack_cyc = -1; xfer_cyc = -1;
    gnt_delay = gd; stall_pct = sp; gap_pct = gp; err_beat = eb; abort_rty = rty;
    exp_adr = $urandom;
    start_i = 1; we_i = we; adr_i = exp_adr; len_i = LW'(len); wr_data_i = wd_last;
    start_cyc = cyc;
    tick();
    start_i = 0; we_i = $urandom; adr_i = $urandom; len_i = LW'($urandom);
    for (int i = 0; i < MB; i++) wr_data_i[i*DW +: DW] = $urandom;
  endtask

  task automatic run_txn(input bit we, input int len, input int gd, input int sp, input int gp,
                         input int eb, input bit rty, output int rel);
    int lc;
    lc = (len > MB) ? MB : len;
    launch(we, len, gd, sp, gp, eb, rty);
    for (int i = 0; i < 600 && n_done == 0; i++) tick();
    tick(); tick();
    if (!we) for (int i = 0; i < counted_beats(lc, eb); i++) model_rd[i] = reply[i];
    rel = (done_cyc < 0) ? -1 : done_cyc - start_cyc;
  endtask

  task automatic test_reset();
    for (int i = 0; i < MB; i++) model_rd[i] = '0;
    rst = 0; tick(); tick();
    n_cmp++; if ({busy_o, done_o, err_o, rty_o, tmo_o, req_wb_o, CYC_O, STB_O, WE_O} !== 9'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b required 0", {busy_o, done_o, err_o, rty_o, tmo_o, req_wb_o, CYC_O, STB_O, WE_O}); end
    n_cmp++; if (rd_data_o !== '0 || ADR_O !== '0 || DAT_O !== '0) begin
      n_bad++; $display("FAIL reset_data: rd=%h adr=%h dat=%h required 0", rd_data_o, ADR_O, DAT_O); end
    n_cmp++; if (SEL_O !== {SW{1'b1}} || CTI_O !== 3'b000) begin
      n_bad++; $display("FAIL reset_sel_cti: sel=%b cti=%b", SEL_O, CTI_O); end
    rst = 1; tick();
  endtask

  task automatic test_write_basic();
    int rel;
    run_txn(1, 4, 0, 0, 0, 99, 0, rel);
    n_cmp++; if (rel !== 7) begin n_bad++; $display("FAIL wr_done_cycle: got %0d required 7", rel); end
    n_cmp++; if (n_acc !== 4) begin n_bad++; $display("FAIL wr_beats: got %0d required 4", n_acc); end
    n_cmp++; if (cnt_data_bad(1, 4) !== 0) begin n_bad++; $display("FAIL wr_data: %0d words wrong", cnt_data_bad(1, 4)); end
    n_cmp++; if ({err_o, rty_o, tmo_o} !== 3'b000) begin n_bad++; $display("FAIL wr_flags: got %b required 000", {err_o, rty_o, tmo_o}); end
    n_cmp++; if (n_done !== 1 || busy_at_done !== 1 || busy_o !== 1'b0) begin
      n_bad++; $display("FAIL wr_done_busy: pulses=%0d busy_at_done=%0d busy_after=%b", n_done, busy_at_done, busy_o); end
    n_cmp++; if (adr_bad !== 0) begin n_bad++; $display("FAIL wr_addr: %0d beats with wrong ADR_O", adr_bad); end
  endtask

  task automatic test_read_stall();
    int rel;
    run_txn(0, 3, 1, 50, 0, 99, 0, rel);
    n_cmp++; if (n_acc !== 3) begin n_bad++; $display("FAIL rd_beats: got %0d required 3", n_acc); end
    n_cmp++; if (cnt_data_bad(0, 3) !== 0) begin n_bad++; $display("FAIL rd_data: %0d slots wrong", cnt_data_bad(0, 3)); end
    n_cmp++; if (done_cyc !== last_ack_cyc + 1 || n_done !== 1) begin
      n_bad++; $display("FAIL rd_done_timing: done at %0d, last ack %0d, pulses %0d", done_cyc, last_ack_cyc, n_done); end
  endtask

  task automatic test_err_abort();
    int rel;
    run_txn(0, 4, 0, 0, 0, 1, 0, rel);
    n_cmp++; if ({err_o, rty_o, tmo_o} !== 3'b100) begin n_bad++; $display("FAIL err_flags: got %b required 100", {err_o, rty_o, tmo_o}); end
    n_cmp++; if (cnt_data_bad(0, 1) !== 0) begin n_bad++; $display("FAIL err_rd_slots: %0d slots wrong", cnt_data_bad(0, 1)); end
    n_cmp++; if (done_cyc !== last_ack_cyc + 1 || cyc_at_done !== 0 || n_done !== 1) begin
      n_bad++; $display("FAIL err_done: done %0d last ack %0d cyc %0d pulses %0d", done_cyc, last_ack_cyc, cyc_at_done, n_done); end
  endtask

  task automatic test_len_bounds();
    int rel;
    run_txn(1, 0, 0, 0, 0, 99, 0, rel);
    n_cmp++; if (rel !== 1 || req_seen !== 0 || n_acc !== 0) begin
      n_bad++; $display("FAIL len0: done rel %0d req_seen %0d beats %0d required 1/0/0", rel, req_seen, n_acc); end
    run_txn(1, MB + 5, 0, 0, 0, 99, 0, rel);
    n_cmp++; if (n_acc !== MB || rel !== 3 + MB) begin
      n_bad++; $display("FAIL len_clamp: beats %0d done rel %0d required %0d/%0d", n_acc, rel, MB, 3 + MB); end
    n_cmp++; if (cnt_data_bad(1, MB) !== 0) begin n_bad++; $display("FAIL len_clamp_data: %0d words wrong", cnt_data_bad(1, MB)); end
  endtask

  task automatic test_reset_mid();
    int rel;
    launch(0, 4, 0, 0, 0, 99, 0);
    for (int i = 0; i < 50 && n_acc < 2; i++) tick();
    rst = 0; tick();
    for (int i = 0; i < MB; i++) model_rd[i] = '0;
    n_cmp++; if ({busy_o, done_o, req_wb_o, CYC_O, STB_O, err_o, rty_o, tmo_o} !== 8'b0 || n_done !== 0) begin
      n_bad++; $display("FAIL mid_reset_outputs: got %b pulses %0d required 0", {busy_o, done_o, req_wb_o, CYC_O, STB_O, err_o, rty_o, tmo_o}, n_done); end
    n_cmp++; if (rd_data_o !== '0) begin n_bad++; $display("FAIL mid_reset_rd: got %h required 0", rd_data_o); end
    rst = 1; tick();
    run_txn(0, 3, 0, 0, 0, 99, 0, rel);
    n_cmp++; if (rel !== 6 || cnt_data_bad(0, 3) !== 0) begin
      n_bad++; $display("FAIL after_reset_txn: done rel %0d required 6, %0d slots wrong", rel, cnt_data_bad(0, 3)); end
  endtask

`ifdef WB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int rel;
    ack_en = 0;
    run_txn(1, 2, 0, 0, 0, 99, 0, rel);
    ack_en = 1;
    n_cmp++; if (tmo_o !== 1'b1 || err_o !== 1'b0 || done_cyc - xfer_cyc !== TMO) begin
      n_bad++; $display("FAIL timeout: tmo %b done-xfer %0d required 1/%0d", tmo_o, done_cyc - xfer_cyc, TMO); end
  endtask
`endif

  task automatic test_random();
    int rel, len, lc, eb;
    bit we, rty;
    for (int t = 0; t < 12; t++) begin
      we  = 1'($urandom);
      len = $urandom_range(MB + 3, 1);
      lc  = (len > MB) ? MB : len;
      eb  = ($urandom_range(3) == 0) ? $urandom_range(lc - 1) : 99;
      rty = 1'($urandom);
      run_txn(we, len, $urandom_range(3), $urandom_range(60), $urandom_range(40), eb, rty, rel);
      n_cmp++; if (eb == 99 && n_acc !== lc) begin n_bad++; $display("FAIL rnd%0d_beats: got %0d required %0d", t, n_acc, lc); end
      n_cmp++; if (cnt_data_bad(we, we ? n_acc : lc) !== 0) begin
        n_bad++; $display("FAIL rnd%0d_data: we=%0d %0d entries wrong", t, we, cnt_data_bad(we, we ? n_acc : lc)); end
      n_cmp++; if ({err_o, rty_o, tmo_o} !== {(eb != 99) && !rty, (eb != 99) && rty, 1'b0}) begin
        n_bad++; $display("FAIL rnd%0d_flags: got %b eb=%0d rty=%0d", t, {err_o, rty_o, tmo_o}, eb, rty); end
      n_cmp++; if (done_cyc !== last_ack_cyc + 1 || n_done !== 1 || adr_bad !== 0) begin
        n_bad++; $display("FAIL rnd%0d_done: done %0d last ack %0d pulses %0d adr_bad %0d", t, done_cyc, last_ack_cyc, n_done, adr_bad); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_write_basic();
    test_read_stall();
    test_err_abort();
    test_len_bounds();
    test_reset_mid();
`ifdef WB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
